// File: rtl/matriz_pkg.sv
// Shared defaults, types and helpers for the row-multiplexed LED matrix scanner.
package matriz_pkg;

    localparam int unsigned DEF_ROWS  = 8;
    localparam int unsigned DEF_COLS  = 8;
    localparam int unsigned DEF_LANES = 4;
    localparam int unsigned DEF_COLW  = 3;
    localparam int unsigned MAX_ROWS  = 64;

    // Lane 0 -> column 0, lane 1 -> 1, lane 2 -> 6, lane 3 -> 7.
    localparam logic [DEF_LANES*DEF_COLW-1:0] DEF_LANE_COLS = {3'd7, 3'd6, 3'd1, 3'd0};

    typedef logic [DEF_ROWS-1:0][DEF_COLS-1:0] frame_t;

    function automatic logic [MAX_ROWS-1:0] onehot_row(input int unsigned idx);
        return MAX_ROWS'(1) << idx;
    endfunction

    function automatic int unsigned lane_bit(input int unsigned lane, input int unsigned row,
                                             input int unsigned rows);
        return lane * rows + row;
    endfunction

endpackage

// File: rtl/matriz_prescaler.sv
// Free-running divide-by-DIV counter; tick_o is high on the last count of every period.
module matriz_prescaler #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == CW'(DIV - 1));
        cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/matriz_scan.sv
// Lane-to-column frame composer with double buffer and row-multiplexed matrix drive.
// Optional row blanking against ghosting is enabled by defining MATRIZ_SCAN_BLANK_EN.
module matriz_scan
    import matriz_pkg::*;
#(
    parameter int unsigned             ROWS      = DEF_ROWS,
    parameter int unsigned             COLS      = DEF_COLS,
    parameter int unsigned             LANES     = DEF_LANES,
    parameter int unsigned             COLW      = DEF_COLW,
    parameter logic [LANES*COLW-1:0]   LANE_COLS = DEF_LANE_COLS,
    parameter int unsigned             DIV       = 50000
) (
    input  logic                  MatrizScan_CLOCK_50,
    input  logic                  MatrizScan_RESET_InLow,
    input  logic [LANES*ROWS-1:0] MatrizScan_Lane_In,
    input  logic                  MatrizScan_Load_In,
    input  logic                  MatrizScan_Clear_In,
    output logic                  MatrizScan_Ready_Out,
    output logic [ROWS-1:0]       MatrizScan_Row_Out,
    output logic [COLS-1:0]       MatrizScan_Col_Out,
    output logic                  MatrizScan_FrameDone_Out
);

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef logic [ROWS-1:0][COLS-1:0] scan_frame_t;

    logic            tick;
    logic            last_row;
    logic            load_ok;
    logic [RW-1:0]   row_idx_q, row_idx_d;
    logic            pending_q, pending_d;
    scan_frame_t     front_q, front_d;
    scan_frame_t     back_q, back_d;
    scan_frame_t     composed;
    logic [ROWS-1:0] row_q, row_d;
    logic [COLS-1:0] col_q, col_d;
    logic            done_q, done_d;

    matriz_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk_i  (MatrizScan_CLOCK_50),
        .rst_ni (MatrizScan_RESET_InLow),
        .tick_o (tick)
    );

    for (genvar l = 0; l < LANES; l++) begin : g_cfg_check
        if (32'(LANE_COLS[l*COLW +: COLW]) >= COLS) begin : g_bad_col
            $error("matriz_scan: lane %0d mapped to column outside the matrix", l);
        end
    end

    // Out-of-range lane columns never match any c, so such lanes drop out naturally.
    always_comb begin
        composed = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int l = 0; l < LANES; l++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (LANE_COLS[l*COLW +: COLW] == COLW'(c)) begin
                        composed[r][c] = composed[r][c] |
                                         MatrizScan_Lane_In[lane_bit(l, r, ROWS)];
                    end
                end
            end
        end
    end

    always_comb begin
        last_row  = (row_idx_q == RW'(ROWS - 1));
        load_ok   = MatrizScan_Load_In && !pending_q;
        row_idx_d = row_idx_q;
        row_d     = row_q;
        col_d     = col_q;
        done_d    = 1'b0;
        front_d   = front_q;
        back_d    = back_q;
        pending_d = pending_q;

        if (tick) begin
            row_d     = ROWS'(onehot_row(32'(row_idx_q)));
            col_d     = front_q[row_idx_q];
            row_idx_d = last_row ? '0 : row_idx_q + 1'b1;
            done_d    = last_row;
        end

        if (MatrizScan_Clear_In) begin
            front_d   = '0;
            back_d    = '0;
            pending_d = 1'b0;
        end else if (tick && last_row && pending_q) begin
            front_d   = back_q;
            pending_d = 1'b0;
        end else if (load_ok) begin
            back_d    = composed;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge MatrizScan_CLOCK_50 or negedge MatrizScan_RESET_InLow) begin
        if (!MatrizScan_RESET_InLow) begin
            row_idx_q <= '0;
            pending_q <= 1'b0;
            front_q   <= '0;
            back_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            row_idx_q <= row_idx_d;
            pending_q <= pending_d;
            front_q   <= front_d;
            back_q    <= back_d;
            row_q     <= row_d;
            col_q     <= col_d;
            done_q    <= done_d;
        end
    end

    assign MatrizScan_Ready_Out     = ~pending_q;
    assign MatrizScan_FrameDone_Out = done_q;

`ifdef MATRIZ_SCAN_BLANK_EN
    localparam int unsigned BLANK = (DIV / 8 > 0) ? DIV / 8 : 1;
    localparam int unsigned BW    = $clog2(BLANK + 1);

    logic [BW-1:0] blank_q, blank_d;

    // Reloaded on every tick; outputs stay dark while the count is non-zero.
    always_comb begin
        blank_d = blank_q;
        if (tick) begin
            blank_d = BW'(BLANK);
        end else if (blank_q != '0) begin
            blank_d = blank_q - 1'b1;
        end
    end

    always_ff @(posedge MatrizScan_CLOCK_50 or negedge MatrizScan_RESET_InLow) begin
        if (!MatrizScan_RESET_InLow) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign MatrizScan_Row_Out = (blank_q != '0) ? '0 : row_q;
    assign MatrizScan_Col_Out = (blank_q != '0) ? '0 : col_q;
`else
    assign MatrizScan_Row_Out = row_q;
    assign MatrizScan_Col_Out = col_q;
`endif

endmodule
